gmii_rx_packer: RTL and testbench
=================================

Name: gmii_rx_packer

Overview:
- Upstream neighbour of the ingress classifier.
- Converts the 8-bit GMII receive stream into the 36-bit packet-word format plus a per-frame 16-bit descriptor.
- Strips the preamble and SFD, packs 4 bytes per word, counts length and flags bad frames.
- Drops whole frames when the downstream data FIFO is almost full.

Parameters:
- MIN_LEN, 64: minimum legal frame length in bytes, FCS included.
- MAX_LEN, 1522: maximum legal frame length in bytes; bytes beyond this are not written.

Ports:
- i_sys_clk  in  1  system clock; GMII receive is already synchronous to it.
- i_sys_rst_n  in  1  asynchronous, active-low reset.
- i_gmii_rx_dv  in  1  receive data valid.
- i_gmii_rx_er  in  1  receive error.
- i_gmii_rxd  in  8  receive byte.
- o_pkt_data  out  36  [35:34] 10 head / 00 body / 01 tail / 11 head+tail; [33:32] valid bytes; [31:0] data, first byte in [31:24].
- o_pkt_data_en  out  1  word strobe.
- o_pkt_val  out  16  [15] frame good, [14] 0, [13:0] byte length.
- o_pkt_val_en  out  1  descriptor strobe.
- i_pkt_data_usedw  in  10  downstream data FIFO used words; bit 9 means almost full.
- o_rx_frame_cnt  out  32  frames forwarded, good or bad.
- o_rx_drop_cnt  out  16  frames dropped for backpressure or preamble error.

Behaviour:
- Reset: all outputs, counters, holding registers and the CRC register clear asynchronously. The FSM enters IDLE with the seen_idle flag cleared.

FSM states: IDLE, PREAMBLE, DATA, DROP, FLUSH.
- IDLE: wait until seen_idle is set (rx_dv has been sampled low at least once), then go to PREAMBLE on rx_dv=1. This prevents locking onto a frame already in progress when reset is released.
- PREAMBLE:
  - rxd=0x55 → stay.
  - rxd=0xD5 with i_pkt_data_usedw[9]=0 → DATA.
  - rxd=0xD5 with i_pkt_data_usedw[9]=1 → DROP, drop counter +1.
  - Any other byte, rx_er=1, or rx_dv=0 → DROP (or IDLE if rx_dv=0), drop counter +1.
- DATA:
  - Shift bytes into the pack register and increment the 14-bit byte count, saturating at 16383.
  - Each completed 4-byte word moves into a one-word hold register. The previously held word is emitted with o_pkt_data_en=1, so every word is delayed until its successor completes or the frame ends.
  - The first emitted word carries marker 10; later words carry 00.
  - rx_er=1 at any point sets the error flag.
  - Bytes beyond MAX_LEN are counted but not packed.
  - rx_dv=0 → FLUSH.
- FLUSH, 1 or 2 cycles:
  - Emit the held word. Then emit the partial pack word, if any bytes are pending, as the tail.
  - The tail is marker 01, or 11 if it is also the first word. Its [33:32] = valid bytes mod 4, where 00 means 4. Unused low bytes are 0. Non-tail words have [33:32]=00.
  - One cycle after the tail word: o_pkt_val_en=1 and o_pkt_val={good,1'b0,len}. good=1 only if: no error, MIN_LEN ≤ len ≤ MAX_LEN, and the CRC is OK (when enabled). Frame counter +1. Then → IDLE.
- Zero bytes after SFD: no words, no descriptor, frame counter unchanged.
- DROP: nothing is written. Exit to IDLE on rx_dv=0.
- Strobes: o_pkt_data_en and o_pkt_val_en are single-cycle and never asserted together.
- Counters: wrap at 2^32 and 2^16 respectively.
- Backpressure: sampled only at the SFD. A frame once accepted is always written completely.

Optional Feature:
- GMII_RX_CRC_CHK_EN defined:
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over every byte after the SFD, FCS included.
  - The final register must equal residue 0xC704DD7B; otherwise o_pkt_val[15]=0.
  - Bytes beyond MAX_LEN are still included in the CRC.
- Not defined: no CRC logic is built and the FCS is passed through unchecked.

Test Plan:
- 7×0x55, 0xD5, 64 bytes 0x00..0x3F, good FCS → 16 words: first [35:34]=10, last =01 with [33:32]=00, first data 0x00010203; then val=0x8040.
- 65-byte good frame → 17 words; tail = {01,01,0x40000000}; val=0x8041.
- i_pkt_data_usedw=0x200 at SFD → no o_pkt_data_en, no o_pkt_val_en, o_rx_drop_cnt=1.
- 64-byte frame with rx_er pulse at byte 20 → 16 words written; val=0x0040.
- 1600-byte frame → 381 words (1522/4 rounded up); tail [33:32]=10; val=0x0640 with [15]=0.
- Reset asserted mid-DATA, released while rx_dv=1 → no output for the rest of that frame; the next frame is packed normally.
- With GMII_RX_CRC_CHK_EN defined: 64-byte frame with one FCS bit flipped → val=0x0040.

Source files
------------

// File: rtl/gmii_rx_packer.sv
// GMII receive packer: strips preamble/SFD, packs bytes into 36-bit words and emits a per-frame descriptor.
// Optional FCS checking is built when GMII_RX_CRC_CHK_EN is defined.
module gmii_rx_packer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst_n,
    input  logic        i_gmii_rx_dv,
    input  logic        i_gmii_rx_er,
    input  logic [7:0]  i_gmii_rxd,
    output logic [35:0] o_pkt_data,
    output logic        o_pkt_data_en,
    output logic [15:0] o_pkt_val,
    output logic        o_pkt_val_en,
    input  logic [9:0]  i_pkt_data_usedw,
    output logic [31:0] o_rx_frame_cnt,
    output logic [15:0] o_rx_drop_cnt
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DROP, FLUSH} state_t;

    localparam logic [13:0] MIN_L = 14'(MIN_LEN);
    localparam logic [13:0] MAX_L = 14'(MAX_LEN);

    state_t      state_q, state_d;
    logic        seen_idle_q, seen_idle_d;
    logic [31:0] pack_q, pack_d;
    logic [1:0]  pack_cnt_q, pack_cnt_d;
    logic [31:0] hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        first_q, first_d;
    logic        err_q, err_d;
    logic [13:0] len_q, len_d;
    logic        desc_pend_q, desc_pend_d;
    logic [35:0] pkt_data_q, pkt_data_d;
    logic        pkt_data_en_q, pkt_data_en_d;
    logic [15:0] pkt_val_q, pkt_val_d;
    logic        pkt_val_en_q, pkt_val_en_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic start_frame;
    logic crc_ok;
    logic good;
    logic unused_usedw;

    assign unused_usedw = ^i_pkt_data_usedw[8:0];
    assign start_frame  = (state_q == PREAMBLE) && i_gmii_rx_dv && !i_gmii_rx_er &&
                          (i_gmii_rxd == 8'hD5) && !i_pkt_data_usedw[9];

`ifdef GMII_RX_CRC_CHK_EN
    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Residue 0xC704DD7B read MSB-first appears bit-reversed in this LSB-first register.
    assign crc_ok = (crc_q == 32'hDEBB20E3);

    always_comb begin
        crc_d = crc_q;
        if (start_frame) begin
            crc_d = 32'hFFFF_FFFF;
        end else if (state_q == DATA && i_gmii_rx_dv) begin
            crc_d = crc_byte(crc_q, i_gmii_rxd);
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) crc_q <= '0;
        else              crc_q <= crc_d;
    end
`else
    assign crc_ok = 1'b1;
`endif

    assign good = !err_q && (len_q >= MIN_L) && (len_q <= MAX_L) && crc_ok;

    always_comb begin
        state_d       = state_q;
        seen_idle_d   = seen_idle_q | ~i_gmii_rx_dv;
        pack_d        = pack_q;
        pack_cnt_d    = pack_cnt_q;
        hold_d        = hold_q;
        hold_vld_d    = hold_vld_q;
        first_d       = first_q;
        err_d         = err_q;
        len_d         = len_q;
        desc_pend_d   = 1'b0;
        pkt_data_d    = pkt_data_q;
        pkt_data_en_d = 1'b0;
        pkt_val_d     = pkt_val_q;
        pkt_val_en_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        drop_cnt_d    = drop_cnt_q;

        if (desc_pend_q) begin
            pkt_val_en_d = 1'b1;
            pkt_val_d    = {good, 1'b0, len_q};
            frame_cnt_d  = frame_cnt_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (seen_idle_q && i_gmii_rx_dv) state_d = PREAMBLE;
            end
            PREAMBLE: begin
                if (!i_gmii_rx_dv) begin
                    state_d    = IDLE;
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end else if (start_frame) begin
                    state_d    = DATA;
                    pack_d     = '0;
                    pack_cnt_d = '0;
                    hold_vld_d = 1'b0;
                    first_d    = 1'b1;
                    err_d      = 1'b0;
                    len_d      = '0;
                end else if (i_gmii_rx_er || i_gmii_rxd != 8'h55) begin
                    state_d    = DROP;
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (!i_gmii_rx_dv) begin
                    state_d = FLUSH;
                end else begin
                    err_d = err_q | i_gmii_rx_er;
                    if (len_q != 14'h3FFF) len_d = len_q + 14'd1;
                    if (len_q < MAX_L) begin
                        if (pack_cnt_q == 2'd3) begin
                            hold_d     = {pack_q[31:8], i_gmii_rxd};
                            hold_vld_d = 1'b1;
                            pack_d     = '0;
                            pack_cnt_d = '0;
                            // The previous word is released only once its successor is complete.
                            if (hold_vld_q) begin
                                pkt_data_d    = {first_q, 1'b0, 2'b00, hold_q};
                                pkt_data_en_d = 1'b1;
                                first_d       = 1'b0;
                            end
                        end else begin
                            case (pack_cnt_q)
                                2'd0:    pack_d[31:24] = i_gmii_rxd;
                                2'd1:    pack_d[23:16] = i_gmii_rxd;
                                default: pack_d[15:8]  = i_gmii_rxd;
                            endcase
                            pack_cnt_d = pack_cnt_q + 2'd1;
                        end
                    end
                end
            end
            FLUSH: begin
                if (hold_vld_q) begin
                    pkt_data_d    = {first_q, (pack_cnt_q == 2'd0), 2'b00, hold_q};
                    pkt_data_en_d = 1'b1;
                    hold_vld_d    = 1'b0;
                    first_d       = 1'b0;
                    if (pack_cnt_q == 2'd0) begin
                        desc_pend_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (pack_cnt_q != 2'd0) begin
                    pkt_data_d    = {first_q, 1'b1, pack_cnt_q, pack_q};
                    pkt_data_en_d = 1'b1;
                    pack_cnt_d    = '0;
                    first_d       = 1'b0;
                    desc_pend_d   = 1'b1;
                    state_d       = IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (!i_gmii_rx_dv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q       <= IDLE;
            seen_idle_q   <= 1'b0;
            pack_q        <= '0;
            pack_cnt_q    <= '0;
            hold_q        <= '0;
            hold_vld_q    <= 1'b0;
            first_q       <= 1'b0;
            err_q         <= 1'b0;
            len_q         <= '0;
            desc_pend_q   <= 1'b0;
            pkt_data_q    <= '0;
            pkt_data_en_q <= 1'b0;
            pkt_val_q     <= '0;
            pkt_val_en_q  <= 1'b0;
            frame_cnt_q   <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            seen_idle_q   <= seen_idle_d;
            pack_q        <= pack_d;
            pack_cnt_q    <= pack_cnt_d;
            hold_q        <= hold_d;
            hold_vld_q    <= hold_vld_d;
            first_q       <= first_d;
            err_q         <= err_d;
            len_q         <= len_d;
            desc_pend_q   <= desc_pend_d;
            pkt_data_q    <= pkt_data_d;
            pkt_data_en_q <= pkt_data_en_d;
            pkt_val_q     <= pkt_val_d;
            pkt_val_en_q  <= pkt_val_en_d;
            frame_cnt_q   <= frame_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign o_pkt_data     = pkt_data_q;
    assign o_pkt_data_en  = pkt_data_en_q;
    assign o_pkt_val      = pkt_val_q;
    assign o_pkt_val_en   = pkt_val_en_q;
    assign o_rx_frame_cnt = frame_cnt_q;
    assign o_rx_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_gmii_rx_packer.sv
// Scoreboard bench for gmii_rx_packer: directed frames push expected words/descriptors, a monitor pops and compares.
module tb_gmii_rx_packer;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1522;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv = 1'b0;
    logic        er = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic [9:0]  usedw = 10'h000;
    logic [35:0] pkt_data;
    logic        pkt_data_en;
    logic [15:0] pkt_val;
    logic        pkt_val_en;
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;

    gmii_rx_packer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .i_sys_clk        (clk),
        .i_sys_rst_n      (rst_n),
        .i_gmii_rx_dv     (dv),
        .i_gmii_rx_er     (er),
        .i_gmii_rxd       (rxd),
        .o_pkt_data       (pkt_data),
        .o_pkt_data_en    (pkt_data_en),
        .o_pkt_val        (pkt_val),
        .o_pkt_val_en     (pkt_val_en),
        .i_pkt_data_usedw (usedw),
        .o_rx_frame_cnt   (frame_cnt),
        .o_rx_drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int exp_frames = 0;
    int exp_drops = 0;
    logic [35:0] exp_w[$];
    logic [15:0] exp_v[$];
    logic [7:0]  fb[0:2047];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pkt_data_en && pkt_val_en) check("strobe_overlap", 64'd1, 64'd0);
            if (pkt_data_en) begin
                if (exp_w.size() == 0) check("word_unexpected", {28'h0, pkt_data}, 64'hDEAD);
                else check("word", {28'h0, pkt_data}, {28'h0, exp_w.pop_front()});
            end
            if (pkt_val_en) begin
                if (exp_v.size() == 0) check("val_unexpected", {48'h0, pkt_val}, 64'hDEAD);
                else check("val", {48'h0, pkt_val}, {48'h0, exp_v.pop_front()});
            end
        end
    end

`ifdef GMII_RX_CRC_CHK_EN
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction
`endif

    task automatic build(input int n, input bit fcs_ok);
        for (int i = 0; i < n; i++) fb[i] = 8'(i);
`ifdef GMII_RX_CRC_CHK_EN
        if (n >= 4) begin
            logic [31:0] c;
            c = 32'hFFFF_FFFF;
            for (int i = 0; i < n - 4; i++) c = crc_upd(c, fb[i]);
            c = ~c;
            for (int k = 0; k < 4; k++) fb[n - 4 + k] = c[8*k +: 8];
            if (!fcs_ok) fb[n - 1][0] = ~fb[n - 1][0];
        end
`endif
    endtask

    task automatic push_expect(input int n, input bit good);
        int pk;
        int nw;
        int ln;
        logic [31:0] d;
        logic [1:0] vb;
        pk = (n > MAX_LEN) ? MAX_LEN : n;
        nw = (pk + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            d = '0;
            for (int k = 0; k < 4; k++) if (4*w + k < pk) d[31 - 8*k -: 8] = fb[4*w + k];
            vb = (w == nw - 1) ? 2'(pk % 4) : 2'b00;
            exp_w.push_back({(w == 0), (w == nw - 1), vb, d});
        end
        if (n > 0) begin
            ln = (n > 16383) ? 16383 : n;
            exp_v.push_back({good, 1'b0, 14'(ln)});
            exp_frames++;
        end
    endtask

    task automatic put(input logic v, input logic e, input logic [7:0] b);
        dv = v; er = e; rxd = b;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        int t;
        repeat (12) put(1'b0, 1'b0, 8'h00);
        t = 0;
        while ((exp_w.size() != 0 || exp_v.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_words", 64'(exp_w.size()), 64'd0);
        check("drain_vals", 64'(exp_v.size()), 64'd0);
        check("frame_cnt", {32'h0, frame_cnt}, 64'(exp_frames));
        check("drop_cnt", {48'h0, drop_cnt}, 64'(exp_drops));
        exp_w.delete();
        exp_v.delete();
    endtask

    task automatic send_frame(input int n, input int err_at, input bit fcs_ok, input bit bp);
        bit good;
        build(n, fcs_ok);
        good = (err_at < 0) && (n >= MIN_LEN) && (n <= MAX_LEN) && fcs_ok;
        if (bp) exp_drops++;
        else push_expect(n, good);
        usedw = bp ? 10'h200 : 10'h000;
        repeat (7) put(1'b1, 1'b0, 8'h55);
        put(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < n; i++) put(1'b1, (i == err_at), fb[i]);
        usedw = 10'h000;
        settle();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_en", {63'h0, pkt_data_en}, 64'd0);
        check("rst_val_en", {63'h0, pkt_val_en}, 64'd0);
        check("rst_data", {28'h0, pkt_data}, 64'd0);
        check("rst_frame_cnt", {32'h0, frame_cnt}, 64'd0);
        check("rst_drop_cnt", {48'h0, drop_cnt}, 64'd0);
        rst_n = 1'b1;
        repeat (3) put(1'b0, 1'b0, 8'h00);

        send_frame(64, -1, 1'b1, 1'b0);     // 16 words, val 0x8040
        send_frame(65, -1, 1'b1, 1'b0);     // tail {01,01,0x40000000}, val 0x8041
        send_frame(64, -1, 1'b1, 1'b1);     // backpressure at SFD: dropped
        send_frame(64, 20, 1'b1, 1'b0);     // rx_er inside frame: val 0x0040
        send_frame(1600, -1, 1'b1, 1'b0);   // truncated at MAX_LEN: 381 words, val 0x0640
        send_frame(1522, -1, 1'b1, 1'b0);   // exactly MAX_LEN: good
        send_frame(4, -1, 1'b1, 1'b0);      // single head+tail word with 4 bytes
        send_frame(3, -1, 1'b1, 1'b0);      // single head+tail word with 3 bytes
        send_frame(0, -1, 1'b1, 1'b0);      // SFD then end: nothing emitted

        // Corrupt preamble byte.
        repeat (3) put(1'b1, 1'b0, 8'h55);
        put(1'b1, 1'b0, 8'h12);
        repeat (3) put(1'b1, 1'b0, 8'h55);
        put(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 10; i++) put(1'b1, 1'b0, 8'(i));
        exp_drops++;
        settle();

`ifdef GMII_RX_CRC_CHK_EN
        send_frame(64, -1, 1'b0, 1'b0);     // FCS bit flipped: val 0x0040
`endif

        // Reset in the middle of a frame, released while rx_dv is still high.
        build(60, 1'b1);
        repeat (7) put(1'b1, 1'b0, 8'h55);
        put(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 6; i++) put(1'b1, 1'b0, fb[i]);
        rst_n = 1'b0;
        for (int i = 6; i < 9; i++) put(1'b1, 1'b0, fb[i]);
        rst_n = 1'b1;
        exp_frames = 0;
        exp_drops = 0;
        put(1'b1, 1'b0, 8'h55);
        put(1'b1, 1'b0, 8'hD5);
        for (int i = 9; i < 60; i++) put(1'b1, 1'b0, fb[i]);
        settle();
        send_frame(64, -1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
